// File: rtl/alu_trace_pkg.sv
// Shared trace-stream definitions: tag codes, receiver states, record layout.
package alu_trace_pkg;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned TAG_W    = 3;
    localparam int unsigned NUM_TAGS = 7;

    localparam logic [TAG_W-1:0] TAG_OPCODE = 3'd0;
    localparam logic [TAG_W-1:0] TAG_A      = 3'd1;
    localparam logic [TAG_W-1:0] TAG_B      = 3'd2;
    localparam logic [TAG_W-1:0] TAG_RESULT = 3'd3;
    localparam logic [TAG_W-1:0] TAG_CARRY  = 3'd4;
    localparam logic [TAG_W-1:0] TAG_BORROW = 3'd5;
    localparam logic [TAG_W-1:0] TAG_PC     = 3'd6;

    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    typedef struct packed {
        logic        [BYTE_W-1:0] opcode;
        logic signed [BYTE_W-1:0] a;
        logic signed [BYTE_W-1:0] b;
        logic signed [BYTE_W-1:0] result;
        logic                     carry;
        logic                     borrow;
        logic        [BYTE_W-1:0] pc;
    } alu_rec_t;

    // Merge one tagged byte into a partially assembled record.
    function automatic alu_rec_t capture_field(alu_rec_t r, logic [TAG_W-1:0] tag,
                                               logic [BYTE_W-1:0] d);
        alu_rec_t o;
        o = r;
        case (tag)
            TAG_OPCODE: o.opcode = d;
            TAG_A:      o.a      = d;
            TAG_B:      o.b      = d;
            TAG_RESULT: o.result = d;
            TAG_CARRY:  o.carry  = d[0];
            TAG_BORROW: o.borrow = d[0];
            TAG_PC:     o.pc     = d;
            default:    o        = r;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/alu_trace_receiver_if.sv
// Trace byte input bus plus the record valid/ready output channel.
interface alu_trace_receiver_if;
    import alu_trace_pkg::*;

    logic        [BYTE_W-1:0] data_in;
    logic        [TAG_W-1:0]  data_type;
    logic                     data_valid;
    logic        [BYTE_W-1:0] rec_opcode;
    logic        [BYTE_W-1:0] rec_pc;
    logic signed [BYTE_W-1:0] rec_a;
    logic signed [BYTE_W-1:0] rec_b;
    logic signed [BYTE_W-1:0] rec_result;
    logic                     rec_carry;
    logic                     rec_borrow;
    logic                     rec_valid;
    logic                     rec_ready;

    // Trace source and record consumer side.
    modport master (
        output data_in, data_type, data_valid, rec_ready,
        input  rec_opcode, rec_pc, rec_a, rec_b, rec_result,
               rec_carry, rec_borrow, rec_valid
    );

    // Receiver side.
    modport slave (
        input  data_in, data_type, data_valid, rec_ready,
        output rec_opcode, rec_pc, rec_a, rec_b, rec_result,
               rec_carry, rec_borrow, rec_valid
    );
endinterface

// File: rtl/alu_trace_recbuf.sv
// One-deep record holding register: publishes a completed frame or drops it.
module alu_trace_recbuf
    import alu_trace_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     load,
    input  alu_rec_t rec_in,
    input  logic     rec_ready,
    output alu_rec_t rec_out,
    output logic     rec_valid,
    output logic     ovf,
    output logic     pub_c
);

    // A frame may load when the slot is empty or is being emptied this cycle.
    assign pub_c = load & (~rec_valid | rec_ready);

    // Holding register, handshake flag and drop pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_out   <= '0;
            rec_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            ovf <= load & ~pub_c;
            if (pub_c) begin
                rec_out   <= rec_in;
                rec_valid <= 1'b1;
            end else if (rec_valid && rec_ready) begin
                rec_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_trace_receiver.sv
// Reassembles seven tagged trace bytes into one ALU record with ordering checks.
module alu_trace_receiver
    import alu_trace_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_trace_receiver_if.slave bus,
    output logic             seq_err,
    output logic             ovf,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [ERR_W-1:0] err_cnt,
    output logic [ERR_W-1:0] ovf_cnt
);

    localparam logic [0:0]       ST_HUNT    = HUNT;
    localparam logic [0:0]       ST_COLLECT = COLLECT;
    localparam logic [TAG_W-1:0] LAST_TAG   = TAG_W'(NUM_TAGS - 1);

    logic [0:0]       state_q, state_n;
    logic [TAG_W-1:0] exp_q, exp_n;
    alu_rec_t         asm_q, asm_n;
    alu_rec_t         rec_q;
    logic             load_c, err_c, pub_c, drop_c;

    // Sequencer state, expected tag and assembly buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HUNT;
            exp_q   <= '0;
            asm_q   <= '0;
        end else begin
            state_q <= state_n;
            exp_q   <= exp_n;
            asm_q   <= asm_n;
        end
    end

    // Next-state, field capture, completion and ordering-error detection.
    always_comb begin
        state_n = state_q;
        exp_n   = exp_q;
        asm_n   = asm_q;
        load_c  = 1'b0;
        err_c   = 1'b0;
        if (bus.data_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (bus.data_type == TAG_OPCODE) begin
                        asm_n   = capture_field(asm_q, TAG_OPCODE, bus.data_in);
                        exp_n   = TAG_A;
                        state_n = ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (bus.data_type == exp_q) begin
                        asm_n = capture_field(asm_q, bus.data_type, bus.data_in);
                        if (exp_q == LAST_TAG) begin
                            load_c  = 1'b1;
                            exp_n   = '0;
                            state_n = ST_HUNT;
                        end else begin
                            exp_n = exp_q + TAG_W'(1);
                        end
                    end else begin
                        err_c = 1'b1;
                        if (bus.data_type == TAG_OPCODE) begin
                            asm_n = capture_field(asm_q, TAG_OPCODE, bus.data_in);
                            exp_n = TAG_A;
                        end else begin
                            exp_n   = '0;
                            state_n = ST_HUNT;
                        end
                    end
                end
                default: begin
                    exp_n   = '0;
                    state_n = ST_HUNT;
                end
            endcase
        end
    end

    // Record output stage; loads from asm_n so the tag-6 byte appears next cycle.
    alu_trace_recbuf u_recbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_c),
        .rec_in    (asm_n),
        .rec_ready (bus.rec_ready),
        .rec_out   (rec_q),
        .rec_valid (bus.rec_valid),
        .ovf       (ovf),
        .pub_c     (pub_c)
    );

    assign drop_c = load_c & ~pub_c;

    assign bus.rec_opcode = rec_q.opcode;
    assign bus.rec_a      = rec_q.a;
    assign bus.rec_b      = rec_q.b;
    assign bus.rec_result = rec_q.result;
    assign bus.rec_carry  = rec_q.carry;
    assign bus.rec_borrow = rec_q.borrow;
    assign bus.rec_pc     = rec_q.pc;

    // Error pulse plus wrapping frame counter and saturating error/drop counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_err   <= 1'b0;
            frame_cnt <= '0;
            err_cnt   <= '0;
            ovf_cnt   <= '0;
        end else begin
            seq_err <= err_c;
            if (pub_c) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
            if (err_c && (err_cnt != {ERR_W{1'b1}})) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
            if (drop_c && (ovf_cnt != {ERR_W{1'b1}})) begin
                ovf_cnt <= ovf_cnt + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_trace_receiver.sv
// Directed bench for alu_trace_receiver; narrow frame counter so the wrap is reachable.
module tb_alu_trace_receiver;
    import alu_trace_pkg::*;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned ERR_W = 8;

    logic             clk;
    logic             rst_n;
    logic             seq_err, ovf;
    logic [CNT_W-1:0] frame_cnt;
    logic [ERR_W-1:0] err_cnt, ovf_cnt;
    int               n_tests;
    int               n_fail;

    alu_trace_receiver_if bus ();

    alu_trace_receiver #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .seq_err   (seq_err),
        .ovf       (ovf),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt),
        .ovf_cnt   (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send(input logic [2:0] t, input logic [7:0] d);
        @(negedge clk);
        bus.data_valid = 1'b1;
        bus.data_type  = t;
        bus.data_in    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.data_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Byte k of f goes out with tag k; optionally raise rec_ready for the tag-6 cycle.
    task automatic send_frame(input logic [55:0] f, input bit raise_ready);
        for (int k = 0; k < 7; k++) begin
            if (k == 6 && raise_ready) bus.rec_ready = 1'b1;
            send(3'(k), f[8*k +: 8]);
        end
    endtask

    task automatic test_reset();
        n_tests++; if (bus.rec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.rec_valid); end
        n_tests++; if ({bus.rec_opcode, bus.rec_a, bus.rec_b, bus.rec_result, bus.rec_pc} !== 40'd0) begin n_fail++; $display("FAIL reset_rec got %h want 0", {bus.rec_opcode, bus.rec_a, bus.rec_b, bus.rec_result, bus.rec_pc}); end
        n_tests++; if ({bus.rec_carry, bus.rec_borrow, seq_err, ovf} !== 4'd0) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {bus.rec_carry, bus.rec_borrow, seq_err, ovf}); end
        n_tests++; if ({frame_cnt, err_cnt, ovf_cnt} !== 24'd0) begin n_fail++; $display("FAIL reset_cnt got %h want 0", {frame_cnt, err_cnt, ovf_cnt}); end
    endtask

    task automatic test_clean_frame();
        logic [55:0] f;
        f = {8'h10, 8'h01, 8'h00, 8'h02, 8'hFD, 8'h05, 8'h21};
        bus.rec_ready = 1'b1;
        for (int k = 0; k < 6; k++) send(3'(k), f[8*k +: 8]);
        n_tests++; if (bus.rec_valid !== 1'b0) begin n_fail++; $display("FAIL clean_early got %b want 0", bus.rec_valid); end
        send(TAG_PC, f[55:48]);
        n_tests++; if (bus.rec_valid !== 1'b1) begin n_fail++; $display("FAIL clean_valid got %b want 1", bus.rec_valid); end
        n_tests++; if ({bus.rec_opcode, bus.rec_a, bus.rec_b, bus.rec_result, bus.rec_pc} !== 40'h21_05_FD_02_10) begin n_fail++; $display("FAIL clean_fields got %h want 2105fd0210", {bus.rec_opcode, bus.rec_a, bus.rec_b, bus.rec_result, bus.rec_pc}); end
        n_tests++; if ({bus.rec_carry, bus.rec_borrow} !== 2'b01) begin n_fail++; $display("FAIL clean_cb got %b want 01", {bus.rec_carry, bus.rec_borrow}); end
        n_tests++; if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL clean_cnt got %0d want 1", frame_cnt); end
        idle();
        n_tests++; if (bus.rec_valid !== 1'b0) begin n_fail++; $display("FAIL clean_accept got %b want 0", bus.rec_valid); end
    endtask

    task automatic test_seq_error();
        send(TAG_OPCODE, 8'h99);
        send(TAG_A, 8'h01);
        send(TAG_RESULT, 8'h02);
        n_tests++; if (seq_err !== 1'b1) begin n_fail++; $display("FAIL seq_pulse got %b want 1", seq_err); end
        n_tests++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL seq_cnt got %0d want 1", err_cnt); end
        send(TAG_CARRY, 8'h00);
        n_tests++; if (seq_err !== 1'b0 || err_cnt !== 8'd1) begin n_fail++; $display("FAIL seq_hunt got seq_err=%b err_cnt=%0d want 0/1", seq_err, err_cnt); end
        send_frame({8'h56, 8'h00, 8'h01, 8'h0A, 8'h04, 8'h06, 8'h55}, 1'b0);
        n_tests++; if (bus.rec_valid !== 1'b1 || bus.rec_opcode !== 8'h55 || bus.rec_pc !== 8'h56) begin n_fail++; $display("FAIL seq_next got v=%b op=%h pc=%h want 1/55/56", bus.rec_valid, bus.rec_opcode, bus.rec_pc); end
        n_tests++; if (frame_cnt !== 8'd2 || {bus.rec_carry, bus.rec_borrow} !== 2'b10) begin n_fail++; $display("FAIL seq_next_cnt got cnt=%0d cb=%b want 2/10", frame_cnt, {bus.rec_carry, bus.rec_borrow}); end
        idle();
    endtask

    task automatic test_restart();
        logic [2:0] tags [10];
        logic [7:0] dat  [10];
        int         pulses, pubs;
        tags = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        dat  = '{8'h11, 8'h01, 8'h02, 8'h22, 8'h03, 8'h04, 8'h07, 8'h01, 8'h00, 8'h40};
        pulses = 0;
        pubs   = 0;
        for (int k = 0; k < 10; k++) begin
            send(tags[k], dat[k]);
            if (seq_err === 1'b1) pulses++;
            if (bus.rec_valid === 1'b1) pubs++;
        end
        n_tests++; if (pulses !== 1 || err_cnt !== 8'd2) begin n_fail++; $display("FAIL restart_err got pulses=%0d err_cnt=%0d want 1/2", pulses, err_cnt); end
        n_tests++; if (pubs !== 1 || frame_cnt !== 8'd3) begin n_fail++; $display("FAIL restart_pub got pubs=%0d cnt=%0d want 1/3", pubs, frame_cnt); end
        n_tests++; if ({bus.rec_opcode, bus.rec_a, bus.rec_b, bus.rec_result, bus.rec_pc} !== 40'h22_03_04_07_40) begin n_fail++; $display("FAIL restart_rec got %h want 2203040740", {bus.rec_opcode, bus.rec_a, bus.rec_b, bus.rec_result, bus.rec_pc}); end
        idle();
    endtask

    task automatic test_backpressure();
        bus.rec_ready = 1'b0;
        send_frame({8'hA0, 8'hFE, 8'hFF, 8'hFF, 8'h80, 8'h7F, 8'h31}, 1'b0);
        n_tests++; if (bus.rec_valid !== 1'b1 || bus.rec_opcode !== 8'h31 || frame_cnt !== 8'd4) begin n_fail++; $display("FAIL bp_first got v=%b op=%h cnt=%0d want 1/31/4", bus.rec_valid, bus.rec_opcode, frame_cnt); end
        n_tests++; if ({bus.rec_carry, bus.rec_borrow, bus.rec_b} !== {2'b10, 8'h80}) begin n_fail++; $display("FAIL bp_bits got %h want 280", {bus.rec_carry, bus.rec_borrow, bus.rec_b}); end
        idle();
        idle();
        send_frame({8'hA1, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h32}, 1'b0);
        n_tests++; if (ovf !== 1'b1 || ovf_cnt !== 8'd1) begin n_fail++; $display("FAIL bp_ovf got ovf=%b ovf_cnt=%0d want 1/1", ovf, ovf_cnt); end
        n_tests++; if (bus.rec_opcode !== 8'h31 || bus.rec_pc !== 8'hA0 || frame_cnt !== 8'd4) begin n_fail++; $display("FAIL bp_hold got op=%h pc=%h cnt=%0d want 31/a0/4", bus.rec_opcode, bus.rec_pc, frame_cnt); end
        idle();
        n_tests++; if (ovf !== 1'b0 || bus.rec_valid !== 1'b1) begin n_fail++; $display("FAIL bp_ovf_end got ovf=%b v=%b want 0/1", ovf, bus.rec_valid); end
        send_frame({8'hA2, 8'h00, 8'h00, 8'h02, 8'h02, 8'h02, 8'h33}, 1'b1);
        n_tests++; if (bus.rec_valid !== 1'b1 || bus.rec_opcode !== 8'h33 || frame_cnt !== 8'd5) begin n_fail++; $display("FAIL bp_same_cycle got v=%b op=%h cnt=%0d want 1/33/5", bus.rec_valid, bus.rec_opcode, frame_cnt); end
        n_tests++; if (ovf !== 1'b0 || ovf_cnt !== 8'd1) begin n_fail++; $display("FAIL bp_no_drop got ovf=%b ovf_cnt=%0d want 0/1", ovf, ovf_cnt); end
        idle();
        n_tests++; if (bus.rec_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b want 0", bus.rec_valid); end
    endtask

    task automatic test_reset_mid();
        bus.rec_ready = 1'b0;
        send_frame({8'hB0, 8'h00, 8'h00, 8'h05, 8'h03, 8'h02, 8'h66}, 1'b0);
        n_tests++; if (bus.rec_valid !== 1'b1 || frame_cnt !== 8'd6) begin n_fail++; $display("FAIL rst_pre got v=%b cnt=%0d want 1/6", bus.rec_valid, frame_cnt); end
        for (int k = 0; k < 4; k++) send(3'(k), 8'h77);
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.rec_valid !== 1'b0 || {bus.rec_opcode, bus.rec_a, bus.rec_b, bus.rec_result, bus.rec_pc} !== 40'd0) begin n_fail++; $display("FAIL rst_async_rec got v=%b rec=%h want 0/0", bus.rec_valid, {bus.rec_opcode, bus.rec_a, bus.rec_b, bus.rec_result, bus.rec_pc}); end
        n_tests++; if ({frame_cnt, err_cnt, ovf_cnt} !== 24'd0) begin n_fail++; $display("FAIL rst_async_cnt got %h want 0", {frame_cnt, err_cnt, ovf_cnt}); end
        @(negedge clk);
        rst_n = 1'b1;
        pulse_check_hunt();
    endtask

    task automatic pulse_check_hunt();
        int pulses;
        pulses = 0;
        for (int k = 4; k < 7; k++) begin
            send(3'(k), 8'h77);
            if (seq_err !== 1'b0) pulses++;
        end
        n_tests++; if (pulses !== 0 || err_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_hunt_err got pulses=%0d err_cnt=%0d want 0/0", pulses, err_cnt); end
        n_tests++; if (bus.rec_valid !== 1'b0 || frame_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_hunt_pub got v=%b cnt=%0d want 0/0", bus.rec_valid, frame_cnt); end
        idle();
    endtask

    task automatic test_saturation();
        for (int k = 1; k <= 300; k++) begin
            send(TAG_OPCODE, 8'(k));
            send(3'd7, 8'h00);
            if (k == 254) begin
                n_tests++; if (err_cnt !== 8'hFE) begin n_fail++; $display("FAIL sat_254 got %h want fe", err_cnt); end
            end
            if (k == 255) begin
                n_tests++; if (err_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_255 got %h want ff", err_cnt); end
            end
        end
        n_tests++; if (err_cnt !== 8'hFF || seq_err !== 1'b1) begin n_fail++; $display("FAIL sat_hold got err_cnt=%h seq_err=%b want ff/1", err_cnt, seq_err); end
        idle();
    endtask

    task automatic test_back_to_back_wrap();
        int bad;
        bad = 0;
        bus.rec_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            send_frame({~8'(i), 8'h01, 8'h00, 8'(i + 1), 8'h02, 8'h01, 8'(i)}, 1'b0);
            if (bus.rec_valid !== 1'b1 || bus.rec_opcode !== 8'(i) || bus.rec_pc !== ~8'(i)) bad++;
            if (i == 254) begin
                n_tests++; if (frame_cnt !== 8'hFF) begin n_fail++; $display("FAIL wrap_max got %h want ff", frame_cnt); end
            end
        end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_records got %0d bad want 0", bad); end
        n_tests++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL wrap_zero got %h want 0", frame_cnt); end
        n_tests++; if (ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL b2b_ovf got %0d want 0", ovf_cnt); end
        idle();
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        bus.data_valid = 1'b0;
        bus.data_type  = '0;
        bus.data_in    = '0;
        bus.rec_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_clean_frame();
        test_seq_error();
        test_restart();
        test_backpressure();
        test_reset_mid();
        test_saturation();
        test_back_to_back_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
